// File: rtl/instr_fetch.sv
// Purpose: program counter plus instruction fetch into a 2-entry queue feeding the decoder.
// Latency: fetch issued at t with rom_rvalid at t+L shows instr_valid at t+L+1; one request in flight.
// Backpressure: instr_ready low holds the head; issue stops when the queue would stay full.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   rom_req/rom_addr  - one-cycle read request to the instruction ROM (always accepted)
//   rom_rvalid/rdata  - read return, 1 or more cycles after rom_req
//   instr_valid/instr/cmd/instr_pc/instr_ready - head instruction handshake to the decoder
//   pc_ctrl/jump_addr - redirect request, honoured only together with a pop
//   halt              - blocks new fetches; in-flight returns and queued words still flow
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rom_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               rom_rvalid,
  input  logic [INSTR_W-1:0] rom_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         cmd,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               pc_ctrl,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_addr;
  logic               outstanding;
  logic               drop;
  logic [1:0]         occ;
  logic [INSTR_W-1:0] q_word [2];
  logic [ADDR_W-1:0]  q_addr [2];

  logic       pop;
  logic       redirect;
  logic       issue;
  logic       ret;
  logic       push;
  logic [1:0] occ_after_pop;

  always_comb begin
    instr_valid   = (occ != 2'd0);
    pop           = instr_valid && instr_ready;
    redirect      = pop && pc_ctrl;
    occ_after_pop = occ - {1'b0, pop};
    issue         = !rst && !halt && !outstanding && !drop &&
                    (occ_after_pop < 2'd2) && !redirect;
    // A return counts while a request is tracked, either live or marked for discard.
    ret           = rom_rvalid && (outstanding || drop);
    // A return landing in a redirect cycle belongs to the abandoned path.
    push          = ret && !drop && !redirect;
  end

  assign rom_req  = issue;
  assign rom_addr = issue ? pc : '0;
  assign instr    = instr_valid ? q_word[0] : '0;
  assign cmd      = instr[INSTR_W-1 -: 6];
  assign instr_pc = instr_valid ? q_addr[0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_addr    <= '0;
      occ         <= 2'd0;
      outstanding <= 1'b0;
      // A request still in flight across reset must not land as a fresh word.
      drop        <= (outstanding || drop) && !rom_rvalid;
    end else begin
      if (redirect) begin
        pc <= jump_addr;
      end else if (issue) begin
        pc <= pc + ADDR_W'(1);
      end

      if (issue) begin
        outstanding <= 1'b1;
        req_addr    <= pc;
      end else if (ret) begin
        outstanding <= 1'b0;
      end

      if (ret) begin
        drop <= 1'b0;
      end else if (redirect && outstanding) begin
        drop <= 1'b1;
      end

      if (redirect) begin
        occ <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  // Queue storage needs no reset: occ alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && !redirect) begin
      if (pop) begin
        q_word[0] <= q_word[1];
        q_addr[0] <= q_addr[1];
      end
      // Slot chosen after the pop so push+pop lands the new word behind the survivor.
      if (push) begin
        q_word[occ_after_pop[0]] <= rom_rdata;
        q_addr[occ_after_pop[0]] <= req_addr;
      end
    end
  end

endmodule
